sqrt_iter_nr: RTL
=================

// Module: sqrt_iter_nr
// PURPOSE
//  Parametrised, handshaked integer square root (non-restoring, one root bit per clock).
//  Next generation of the fixed 16-bit sqrt datapath, which was driven by an external iteration counter.
//  Generalised to any even width DW, with an internal sequencer, start/done handshake, abort and a busy flag.
//  Sits between operand registers and the result bus of the arithmetic unit.
//  Computes Q = floor(sqrt(D)) and remainder R = D - Q*Q.
// PARAMETERS
//  DW    16   operand width; even, >= 4 (elaboration error otherwise)
//  QW    DW/2 root width (localparam, derived)
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     asynchronous, active-high reset
//  start      in   1     request; sampled only in IDLE
//  abort      in   1     synchronous cancel of an operation in flight
//  D          in   DW    radicand, unsigned; captured on accepted start
//  busy       out  1     high while in CALC or FIX
//  done       out  1     one-cycle pulse: Q/remainder valid
//  Q          out  QW    root, unsigned
//  remainder  out  QW+1  D - Q*Q, unsigned (max 2*(2^QW-1))
// BEHAVIOUR
//  Reset (async, any state):
//   - State goes to IDLE.
//   - busy=0, done=0, Q=0, remainder=0.
//   - Internal operand, partial root, signed residue and counter are cleared.
//  FSM states: IDLE, CALC, FIX.
//   - IDLE -> CALC on start=1: latch D, residue=0, root=0, cnt=QW-1.
//   - CALC, one iteration per edge, taking bits D[2cnt+1:2cnt], MSB pair first:
//       r' = residue>=0 ? (residue<<2 | pair) - (root<<2 | 1)
//                       : (residue<<2 | pair) + (root<<2 | 3)
//       root' = root<<1 | (r'>=0)
//   - After the cnt==0 iteration, go to FIX.
//   - FIX:
//       if residue<0, residue += (root<<1 | 1);
//       register Q=root and remainder=residue[QW:0];
//       assert done=1 for 1 cycle; go to IDLE.
//  Widths: residue is signed QW+2 bits; no overflow is possible for any DW-bit D.
//  Latency: start sampled at edge N -> done high after edge N+QW+1, for exactly one cycle.
//  Throughput: a new start may be accepted in the cycle done is high.
//   - Back-to-back operations therefore take QW+2 cycles each.
//  Outputs:
//   - Q/remainder hold their last result until the next FIX.
//   - They do not change on start or on abort.
//  start while busy: ignored, no queueing; D changes while busy have no effect.
//  abort=1 in CALC/FIX:
//   - Return to IDLE at the next edge with no done pulse.
//   - Q/remainder keep the previous result.
//   - abort has priority over FIX completion; abort in IDLE is a no-op.
//  start and abort both high in IDLE: start wins (abort has no effect in IDLE).
//  Reset asserted mid-operation: immediate IDLE with all outputs 0, no done pulse.
//   - The first start after reset release is handled normally.
//  busy = (state != IDLE); done is never high while busy.
// TESTING (DW=16 unless noted)
//  1. D=127, start 1 cycle -> busy for 9 cycles; done exactly 9 edges after start edge; Q=11, remainder=6.
//  2. Boundaries:
//     - D=0    -> Q=0,   rem=0
//     - D=144  -> Q=12,  rem=0
//     - D=65535 -> Q=255, rem=510
//     - D=1    -> Q=1,   rem=0
//  3. Back-to-back: start D=200, then start D=99 in the done cycle
//     -> results 14/4, then 9/18, with 10 cycles between done pulses;
//     start pulsed mid-CALC with D=4 is ignored.
//  4. abort at 4th CALC cycle of D=1000, after prior result 11/6
//     -> no done; busy falls next edge; Q=11, rem=6 unchanged; next D=1000 gives 31/39.
//  5. reset pulse mid-CALC (not clock aligned) -> busy/done/Q/remainder go 0 immediately;
//     a subsequent D=50 gives 7/1.
//  6. DW=8 and DW=32 sweeps against a floor-sqrt reference model:
//     - exhaustive for DW=8
//     - for DW=32: 10k random values plus 0, 2^32-1 and squares k^2, k^2-1
//     - Q*Q+rem==D, rem<=2Q, latency QW+1.

Source files
------------

// File: rtl/sqrt_iter_nr.sv
// Sequenced non-restoring integer square root: one root bit per clock,
// start/done handshake with abort. Q = floor(sqrt(D)), remainder = D - Q*Q.
module sqrt_iter_nr #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [DW-1:0]   D,
  output logic            busy,
  output logic            done,
  output logic [DW/2-1:0] Q,
  output logic [DW/2:0]   remainder
);

  localparam int QW = DW / 2;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  if ((DW < 4) || (DW % 2 != 0)) begin : g_dw_check
    $error("sqrt_iter_nr: DW must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                 state_q;
  logic [DW-1:0]          d_q;
  logic [QW-1:0]          root_q, root_d;
  logic signed [QW+1:0]   res_q, res_d;
  logic [CW-1:0]          cnt_q;
  logic [QW-1:0]          q_q;
  logic [QW:0]            rem_q, rem_d;
  logic                   done_q;

  // One non-restoring step: subtract the trial term while the residue is
  // non-negative, add it back (folded with the next trial) while negative.
  function automatic logic signed [QW+1:0] nr_step(
    input logic signed [QW+1:0] r,
    input logic [QW-1:0]        root,
    input logic [1:0]           pair
  );
    logic signed [QW+1:0] sh;
    sh = {r[QW-1:0], pair};
    if (!r[QW+1]) return sh - $signed({root, 2'b01});
    else          return sh + $signed({root, 2'b11});
  endfunction

  // Final correction; the true remainder is non-negative and fits in QW+1
  // bits, so the addition can be done modulo 2^(QW+1).
  function automatic logic [QW:0] nr_fix(
    input logic signed [QW+1:0] r,
    input logic [QW-1:0]        root
  );
    if (r[QW+1]) return r[QW:0] + {root, 1'b1};
    else         return r[QW:0];
  endfunction

  always_comb begin
    res_d  = nr_step(res_q, root_q, d_q[DW-1 -: 2]);
    root_d = {root_q[QW-2:0], ~res_d[QW+1]};
    rem_d  = nr_fix(res_q, root_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      root_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            d_q     <= D;
            res_q   <= '0;
            root_q  <= '0;
            cnt_q   <= CW'(QW - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            res_q  <= res_d;
            root_q <= root_d;
            d_q    <= {d_q[DW-3:0], 2'b00};
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= FIX;
          end
        end
        FIX: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            q_q     <= root_q;
            rem_q   <= rem_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign Q         = q_q;
  assign remainder = rem_q;

endmodule
